// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light display: lamp codes, conversion FSM
// states and active-low 7-segment glyphs ({dp,g,f,e,d,c,b,a}).
package traffic_pkg;

  localparam logic [2:0] CTRL_IDLE = 3'b000;
  localparam logic [2:0] CTRL_G    = 3'b001;
  localparam logic [2:0] CTRL_Y    = 3'b010;
  localparam logic [2:0] CTRL_R    = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } conv_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  function automatic logic [7:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'd0:    seg_glyph = 8'hC0;
      4'd1:    seg_glyph = 8'hF9;
      4'd2:    seg_glyph = 8'hA4;
      4'd3:    seg_glyph = 8'hB0;
      4'd4:    seg_glyph = 8'h99;
      4'd5:    seg_glyph = 8'h92;
      4'd6:    seg_glyph = 8'h82;
      4'd7:    seg_glyph = 8'hF8;
      4'd8:    seg_glyph = 8'h80;
      4'd9:    seg_glyph = 8'h90;
      default: seg_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/traffic_display_bin2bcd_seq.sv
// Sequential subtract-10 binary-to-BCD converter for a 0..31 count.
// Handshake: start is sampled only in S_IDLE; done pulses for exactly the S_DONE
// cycle, during which tens/ones/cnt hold the finished result for the consumer.
module bin2bcd_seq
  import traffic_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [4:0]  bin,
  output logic        done,
  output logic [3:0]  tens,
  output logic [3:0]  ones,
  output logic [4:0]  cnt,
  output conv_state_t state
);

  logic [4:0] rem;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      rem   <= '0;
      tens  <= '0;
      ones  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rem   <= bin;
            cnt   <= bin;
            tens  <= '0;
            state <= S_SUB;
          end
        end
        S_SUB: begin
          if (rem >= 5'd10) begin
            rem  <= rem - 5'd10;
            tens <= tens + 4'd1;
          end else begin
            ones  <= rem[3:0];
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/traffic_display.sv
// Two-digit multiplexed countdown display with lamp LEDs for the traffic-light
// controller: input synchroniser, BCD conversion, scan and blink timing.
module traffic_display
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter int BLINK_TH  = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [4:0] light_t,
  input  logic [2:0] light_ctrl,
  output logic [1:0] seg_sel,
  output logic [7:0] seg_data,
  output logic [2:0] led,
  output logic       code_err
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [4:0] t_s1, t_s2, t_stab;
  logic [2:0] c_s1, c_s2, c_stab;
  logic [4:0] last_cnt;
  logic       never_conv;
  logic [7:0] tens_seg, ones_seg;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic       dig_idx, blink_on;

  logic        conv_start, conv_done;
  logic [3:0]  conv_tens, conv_ones;
  logic [4:0]  conv_cnt;
  conv_state_t conv_state;

  logic       scan_wrap, blink_wrap, idx_nxt, blink_nxt;
  logic       legal, showing, blank_act;
  logic [1:0] sel_nxt;
  logic [7:0] seg_nxt;
  logic [2:0] led_nxt;

  assign conv_start = (conv_state == S_IDLE) && (never_conv || (t_stab != last_cnt));

  bin2bcd_seq u_conv (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (conv_start),
    .bin      (t_stab),
    .done     (conv_done),
    .tens     (conv_tens),
    .ones     (conv_ones),
    .cnt      (conv_cnt),
    .state    (conv_state)
  );

  // Outputs are computed from next-cycle scan/blink values so a coincident
  // digit switch and blink toggle appear together on the same edge.
  always_comb begin
    scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
    idx_nxt    = dig_idx ^ scan_wrap;
    blink_nxt  = blink_on ^ blink_wrap;
    case (c_stab)
      CTRL_IDLE, CTRL_G, CTRL_Y, CTRL_R: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    showing   = legal && (c_stab != CTRL_IDLE);
    blank_act = (c_stab == CTRL_Y) && (t_stab != 5'd0) && (t_stab <= 5'(BLINK_TH));
    sel_nxt   = idx_nxt ? 2'b10 : 2'b01;
    seg_nxt   = !showing ? SEG_DASH : (idx_nxt ? tens_seg : ones_seg);
    led_nxt   = legal ? c_stab : 3'b000;
    if (blank_act && !blink_nxt) begin
      seg_nxt = SEG_BLANK;
      led_nxt = 3'b000;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      t_s1       <= '0;
      t_s2       <= '0;
      t_stab     <= '0;
      c_s1       <= '0;
      c_s2       <= '0;
      c_stab     <= '0;
      last_cnt   <= 5'd31;
      never_conv <= 1'b1;
      tens_seg   <= SEG_DASH;
      ones_seg   <= SEG_DASH;
      scan_cnt   <= '0;
      blink_cnt  <= '0;
      dig_idx    <= 1'b0;
      blink_on   <= 1'b1;
      seg_sel    <= 2'b11;
      seg_data   <= SEG_BLANK;
      led        <= 3'b000;
      code_err   <= 1'b0;
    end else begin
      t_s1 <= light_t;
      t_s2 <= t_s1;
      c_s1 <= light_ctrl;
      c_s2 <= c_s1;
      if (t_s1 == t_s2) t_stab <= t_s2;
      if (c_s1 == c_s2) c_stab <= c_s2;
      if (conv_done) begin
        tens_seg   <= (conv_tens == 4'd0) ? SEG_BLANK : seg_glyph(conv_tens);
        ones_seg   <= seg_glyph(conv_ones);
        last_cnt   <= conv_cnt;
        never_conv <= 1'b0;
      end
      scan_cnt  <= scan_wrap  ? '0 : scan_cnt + SCAN_W'(1);
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
      dig_idx   <= idx_nxt;
      blink_on  <= blink_nxt;
      seg_sel   <= sel_nxt;
      seg_data  <= seg_nxt;
      led       <= led_nxt;
      code_err  <= !legal;
    end
  end

endmodule

// File: tb/tb_traffic_display.sv
// Self-checking bench for traffic_display: vector table, randomized checks
// against a count/10 reference model, and hand-written timing sequences.
module tb_traffic_display;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [4:0] light_t = '0;
  logic [2:0] light_ctrl = '0;
  logic [1:0] seg_sel;
  logic [7:0] seg_data;
  logic [2:0] led;
  logic       code_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] glyph_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    logic [2:0] ctrl;
    logic [4:0] t;
    logic [7:0] tens;
    logic [7:0] ones;
    logic [2:0] led;
    logic       err;
  } vec_t;

  vec_t vecs [12];
  logic [31:0] exp_q [$];

  traffic_display #(.SCAN_DIV(4), .BLINK_DIV(8), .BLINK_TH(3)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .light_t   (light_t),
    .light_ctrl(light_ctrl),
    .seg_sel   (seg_sel),
    .seg_data  (seg_data),
    .led       (led),
    .code_err  (code_err)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [4:0] t);
    light_ctrl = c;
    light_t    = t;
  endtask

  // Capture one sample of each digit slot; bounded so a stuck scan still ends.
  task automatic sample_slots(output logic [7:0] tens_v, output logic [7:0] ones_v, output bit ok);
    bit got_t = 1'b0;
    bit got_o = 1'b0;
    tens_v = '0;
    ones_v = '0;
    for (int i = 0; i < 24 && !(got_t && got_o); i++) begin
      @(negedge sys_clk);
      if (seg_sel == 2'b10 && !got_t) begin tens_v = seg_data; got_t = 1'b1; end
      if (seg_sel == 2'b01 && !got_o) begin ones_v = seg_data; got_o = 1'b1; end
    end
    ok = got_t && got_o;
  endtask

  // Reference model from the display rules (no blink applied).
  function automatic logic [7:0] model_slot(input logic [2:0] c, input logic [4:0] t, input bit tens_slot);
    int tv, ov;
    if (!(c == 3'b001 || c == 3'b010 || c == 3'b100)) return 8'hBF;
    tv = int'(t) / 10;
    ov = int'(t) % 10;
    if (tens_slot) return (tv == 0) ? 8'hFF : glyph_tab[tv];
    return glyph_tab[ov];
  endfunction

  function automatic logic [2:0] model_led(input logic [2:0] c);
    return (c == 3'b001 || c == 3'b010 || c == 3'b100) ? c : 3'b000;
  endfunction

  function automatic logic model_err(input logic [2:0] c);
    return !(c == 3'b000 || c == 3'b001 || c == 3'b010 || c == 3'b100);
  endfunction

  task automatic check_display(input string name, input logic [7:0] et, input logic [7:0] eo,
                               input logic [2:0] el, input logic ee);
    logic [7:0] tv, ov;
    bit ok;
    sample_slots(tv, ov, ok);
    check({name, "_slots_seen"}, 32'(ok), 32'd1);
    exp_q.push_back({24'd0, et});
    exp_q.push_back({24'd0, eo});
    check({name, "_tens"}, {24'd0, tv}, exp_q.pop_front());
    check({name, "_ones"}, {24'd0, ov}, exp_q.pop_front());
    @(negedge sys_clk);
    check({name, "_led"}, {29'd0, led}, {29'd0, el});
    check({name, "_err"}, {31'd0, code_err}, {31'd0, ee});
  endtask

  initial begin
    logic [2:0] codes [8];
    logic [2:0] led_h [48];
    logic [7:0] seg_h [48];
    logic [1:0] sel_h [48];
    int last_tr, n_tr, bad, gap_bad;
    bit seen_t, seen_o;

    vecs[0]  = '{3'b001, 5'd15, 8'hF9, 8'h92, 3'b001, 1'b0};
    vecs[1]  = '{3'b100, 5'd7,  8'hFF, 8'hF8, 3'b100, 1'b0};
    vecs[2]  = '{3'b100, 5'd31, 8'hB0, 8'hF9, 3'b100, 1'b0};
    vecs[3]  = '{3'b100, 5'd0,  8'hFF, 8'hC0, 3'b100, 1'b0};
    vecs[4]  = '{3'b010, 5'd4,  8'hFF, 8'h99, 3'b010, 1'b0};
    vecs[5]  = '{3'b010, 5'd0,  8'hFF, 8'hC0, 3'b010, 1'b0};
    vecs[6]  = '{3'b011, 5'd12, 8'hBF, 8'hBF, 3'b000, 1'b1};
    vecs[7]  = '{3'b110, 5'd20, 8'hBF, 8'hBF, 3'b000, 1'b1};
    vecs[8]  = '{3'b000, 5'd5,  8'hBF, 8'hBF, 3'b000, 1'b0};
    vecs[9]  = '{3'b001, 5'd10, 8'hF9, 8'hC0, 3'b001, 1'b0};
    vecs[10] = '{3'b001, 5'd29, 8'hA4, 8'h90, 3'b001, 1'b0};
    vecs[11] = '{3'b100, 5'd19, 8'hF9, 8'h90, 3'b100, 1'b0};

    // reset held low for 3 cycles
    drive(3'b000, 5'd0);
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_seg_sel", {30'd0, seg_sel}, 32'h3);
    check("rst_seg_data", {24'd0, seg_data}, 32'hFF);
    check("rst_led", {29'd0, led}, 32'h0);
    check("rst_code_err", {31'd0, code_err}, 32'h0);
    sys_rst_n = 1'b1;
    step(12);
    check_display("idle_after_rst", 8'hBF, 8'hBF, 3'b000, 1'b0);

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      step(1);
      drive(vecs[i].ctrl, vecs[i].t);
      step(12);
      check_display($sformatf("vec%0d", i), vecs[i].tens, vecs[i].ones, vecs[i].led, vecs[i].err);
    end

    // conversion latency: red 7 -> 31 must show B0/F9 within the bound
    step(1);
    drive(3'b100, 5'd7);
    step(12);
    drive(3'b100, 5'd31);
    seen_t = 1'b0;
    seen_o = 1'b0;
    for (int i = 0; i < 18 && !(seen_t && seen_o); i++) begin
      @(negedge sys_clk);
      if (seg_sel == 2'b10 && seg_data == 8'hB0) seen_t = 1'b1;
      if (seg_sel == 2'b01 && seg_data == 8'hF9) seen_o = 1'b1;
    end
    check("latency_31", {31'd0, seen_t && seen_o}, 32'd1);

    // yellow blink at count 3
    step(1);
    drive(3'b010, 5'd3);
    step(12);
    for (int i = 0; i < 48; i++) begin
      @(negedge sys_clk);
      led_h[i] = led;
      seg_h[i] = seg_data;
      sel_h[i] = seg_sel;
    end
    last_tr = -1;
    n_tr = 0;
    gap_bad = 0;
    bad = 0;
    for (int i = 1; i < 48; i++) begin
      if (led_h[i] != led_h[i-1]) begin
        if (last_tr >= 0 && (i - last_tr) != 8) gap_bad++;
        last_tr = i;
        n_tr++;
      end
    end
    for (int i = 0; i < 48; i++) begin
      if (led_h[i] == 3'b000) begin
        if (seg_h[i] != 8'hFF) bad++;
      end else if (led_h[i] == 3'b010) begin
        if (sel_h[i] == 2'b01 && seg_h[i] != 8'hB0) bad++;
        if (sel_h[i] == 2'b10 && seg_h[i] != 8'hFF) bad++;
      end else begin
        bad++;
      end
    end
    check("blink_transitions", 32'(n_tr >= 4), 32'd1);
    check("blink_half_period", 32'(gap_bad), 32'd0);
    check("blink_content", 32'(bad), 32'd0);

    // yellow at count 4 never blanks
    drive(3'b010, 5'd4);
    step(12);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge sys_clk);
      if (led != 3'b010) bad++;
      if (seg_sel == 2'b01 && seg_data != 8'h99) bad++;
    end
    check("no_blink_at_4", 32'(bad), 32'd0);

    // illegal code, then exact 4-cycle recovery of code_err
    step(1);
    drive(3'b011, 5'd12);
    step(12);
    check_display("illegal_011", 8'hBF, 8'hBF, 3'b000, 1'b1);
    step(1);
    drive(3'b001, 5'd12);
    step(3);
    @(negedge sys_clk);
    check("code_err_hold_3", {31'd0, code_err}, 32'd1);
    step(1);
    @(negedge sys_clk);
    check("code_err_clear_4", {31'd0, code_err}, 32'd0);
    check("led_green_4", {29'd0, led}, 32'h1);

    // count change during subtraction, then reset mid-conversion
    step(1);
    drive(3'b001, 5'd0);
    step(12);
    drive(3'b001, 5'd31);
    step(4);
    light_t = 5'd30;
    step(1);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("midrst_seg_sel", {30'd0, seg_sel}, 32'h3);
    check("midrst_seg_data", {24'd0, seg_data}, 32'hFF);
    check("midrst_led", {29'd0, led}, 32'h0);
    check("midrst_code_err", {31'd0, code_err}, 32'h0);
    step(1);
    sys_rst_n = 1'b1;
    step(14);
    check_display("after_midrst_30", 8'hB0, 8'hC0, 3'b001, 1'b0);

    // randomized against the reference model (blink window avoided)
    codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 25; i++) begin
      logic [2:0] c;
      logic [4:0] t;
      c = codes[$urandom_range(0, 7)];
      t = 5'($urandom_range(0, 31));
      if (c == 3'b010 && t >= 5'd1 && t <= 5'd3) t = t + 5'd4;
      step(1);
      drive(c, t);
      step(12);
      check_display($sformatf("rnd%0d_c%0b_t%0d", i, c, t),
                    model_slot(c, t, 1'b1), model_slot(c, t, 1'b0), model_led(c), model_err(c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
